// File: rtl/busfifo_pkg.sv
// busfifo_pkg: register offsets, STATUS/CTRL bit positions and FSM states for bus_fifo_port.
// Contents: OFF_* register offsets, ST_* STATUS bits, CT_* CTRL bits, state_t bus FSM states.
package busfifo_pkg;
    localparam logic [1:0] OFF_DATA = 2'd0;
    localparam logic [1:0] OFF_STAT = 2'd1;
    localparam logic [1:0] OFF_CTRL = 2'd2;

    localparam int ST_RX_NE    = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_OVF      = 4;
    localparam int ST_UDF      = 5;
    localparam int ST_IRQ_EN   = 6;
    localparam int ST_IRQ      = 7;

    localparam int CT_FLUSH  = 0;
    localparam int CT_IRQ_EN = 1;

    typedef enum logic [1:0] {S_IDLE, S_SEL, S_READ, S_WRITE} state_t;
endpackage

// File: rtl/bus_fifo_port_if.sv
// bus_fifo_port_if: demultiplexed 8088 peripheral-side bus controls.
// Signals: ale (address latch enable), rd_n/wr_n (active-low strobes), addr (20-bit address).
// Modports: master drives the bus, slave (peripheral) samples it.
interface bus_fifo_port_if;
    logic        ale;
    logic        rd_n;
    logic        wr_n;
    logic [19:0] addr;
    modport master (output ale, rd_n, wr_n, addr);
    modport slave  (input ale, rd_n, wr_n, addr);
endinterface

// File: rtl/byte_fifo.sv
// byte_fifo: DEPTH-entry byte FIFO with synchronous flush.
// Ports: i_clk, i_rst_n (async active-low), i_flush, i_push/i_din, i_pop, o_dout (head, 0 when empty),
//        o_full, o_empty. Push at full is accepted only together with a pop; pop at empty is ignored.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_flush,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic [7:0] o_dout,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = r_count == '0;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_dout  = o_empty ? 8'h00 : r_mem[r_rptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wptr] <= i_din;
    end
endmodule

// File: rtl/bus_fifo_port.sv
// bus_fifo_port: memory-mapped TX/RX byte-FIFO peripheral on the demultiplexed 8088 bus.
// Ports: i_clk, i_rst_n (async active-low), i_bus (ale/rd_n/wr_n/addr), io_data (tri-state bus data),
//        o_tx_valid/o_tx_data/i_tx_ready (TX drain), i_rx_valid/i_rx_data/o_rx_ready (RX fill),
//        o_irq (only when BUSFIFO_IRQ_EN is defined).
// Registers at BASE_ADDR+0 DATA, +1 STATUS, +2 CTRL, +3 reserved.
module bus_fifo_port
    import busfifo_pkg::*;
#(
    parameter logic [19:0] BASE_ADDR = 20'h0_8000,
    parameter int          DEPTH     = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    bus_fifo_port_if.slave  i_bus,
    inout  wire  [7:0]      io_data,
    output logic            o_tx_valid,
    output logic [7:0]      o_tx_data,
    input  logic            i_tx_ready,
    input  logic            i_rx_valid,
    input  logic [7:0]      i_rx_data,
    output logic            o_rx_ready
`ifdef BUSFIFO_IRQ_EN
    ,
    output logic            o_irq
`endif
);
    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_off;
    logic [7:0] r_rdata;
    logic [7:0] r_wdata;
    logic       r_rd_empty;
    logic       r_ovf;
    logic       r_udf;
    logic       r_irq_en;
    logic       w_match;
    logic       w_latch;
    logic       w_load;
    logic       w_cap;
    logic       w_rd_done;
    logic       w_wr_done;
    logic       w_tx_push;
    logic       w_rx_pop;
    logic       w_flush;
    logic       w_tx_full;
    logic       w_tx_empty;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic [7:0] w_rx_dout;
    logic [7:0] w_status;
    logic [7:0] w_ctrl;
    logic [7:0] w_rvalue;
    logic       w_irq_pend;

    assign w_match = i_bus.addr[19:2] == BASE_ADDR[19:2];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    // ALE during an access abandons it and re-decodes the new address as IDLE would.
    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_load    = 1'b0;
        w_cap     = 1'b0;
        w_rd_done = 1'b0;
        w_wr_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_latch = i_bus.ale && w_match;
                w_next  = w_latch ? S_SEL : S_IDLE;
            end
            S_SEL: begin
                if (!i_bus.rd_n) begin
                    w_next = S_READ;
                    w_load = 1'b1;
                end else if (!i_bus.wr_n) begin
                    w_next = S_WRITE;
                    w_cap  = 1'b1;
                end else if (i_bus.ale) begin
                    w_latch = w_match;
                    w_next  = w_match ? S_SEL : S_IDLE;
                end
            end
            S_READ: begin
                if (i_bus.ale) begin
                    w_latch = w_match;
                    w_next  = w_match ? S_SEL : S_IDLE;
                end else if (i_bus.rd_n) begin
                    w_next    = S_IDLE;
                    w_rd_done = 1'b1;
                end
            end
            S_WRITE: begin
                if (i_bus.ale) begin
                    w_latch = w_match;
                    w_next  = w_match ? S_SEL : S_IDLE;
                end else if (i_bus.wr_n) begin
                    w_next    = S_IDLE;
                    w_wr_done = 1'b1;
                end else begin
                    w_cap = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_status              = 8'h00;
        w_status[ST_RX_NE]    = !w_rx_empty;
        w_status[ST_TX_FULL]  = w_tx_full;
        w_status[ST_TX_EMPTY] = w_tx_empty;
        w_status[ST_RX_FULL]  = w_rx_full;
        w_status[ST_OVF]      = r_ovf;
        w_status[ST_UDF]      = r_udf;
        w_status[ST_IRQ_EN]   = r_irq_en;
        w_status[ST_IRQ]      = w_irq_pend;
        w_ctrl                = 8'h00;
        w_ctrl[CT_IRQ_EN]     = r_irq_en;
    end

    assign w_rvalue  = r_off == OFF_DATA ? w_rx_dout :
                       r_off == OFF_STAT ? w_status  :
                       r_off == OFF_CTRL ? w_ctrl    : 8'h00;
    assign w_tx_push = w_wr_done && r_off == OFF_DATA;
    assign w_flush   = w_wr_done && r_off == OFF_CTRL && r_wdata[CT_FLUSH];
    // The pop decision is taken from RX state when the data was loaded, so the CPU never loses a byte
    // that arrived after it was handed 8'h00.
    assign w_rx_pop  = w_rd_done && r_off == OFF_DATA && !r_rd_empty;
    assign io_data   = r_state == S_READ ? r_rdata : 8'hzz;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_off      <= '0;
            r_rdata    <= '0;
            r_wdata    <= '0;
            r_rd_empty <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_irq_en   <= 1'b0;
        end else begin
            if (w_latch) r_off <= i_bus.addr[1:0];
            if (w_load) begin
                r_rdata    <= w_rvalue;
                r_rd_empty <= w_rx_empty;
            end
            if (w_cap) r_wdata <= io_data;
            if (w_flush) begin
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end else begin
                if (w_tx_push && w_tx_full && !i_tx_ready) r_ovf <= 1'b1;
                if (w_rd_done && r_off == OFF_STAT) begin
                    r_ovf <= 1'b0;
                    r_udf <= 1'b0;
                end
                if (w_rd_done && r_off == OFF_DATA && r_rd_empty) r_udf <= 1'b1;
            end
            if (w_wr_done && r_off == OFF_CTRL) r_irq_en <= r_wdata[CT_IRQ_EN];
        end
    end

`ifdef BUSFIFO_IRQ_EN
    logic r_irq;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_irq <= 1'b0;
        else r_irq <= r_irq_en && !w_rx_empty;
    end
    assign o_irq      = r_irq;
    assign w_irq_pend = r_irq;
`else
    assign w_irq_pend = 1'b0;
`endif

    assign o_tx_valid = !w_tx_empty;
    assign o_rx_ready = !w_rx_full;

    byte_fifo #(.DEPTH(DEPTH)) u_tx (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (w_flush),
        .i_push  (w_tx_push),
        .i_din   (r_wdata),
        .i_pop   (i_tx_ready),
        .o_dout  (o_tx_data),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_rx (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (w_flush),
        .i_push  (i_rx_valid && o_rx_ready),
        .i_din   (i_rx_data),
        .i_pop   (w_rx_pop),
        .o_dout  (w_rx_dout),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );
endmodule

// File: doc/bus_fifo_port.md
# bus_fifo_port

Memory-mapped byte-FIFO peripheral that sits directly downstream of the 8088 bus interface and consumes its peripheral view (demultiplexed Address, Data, ALE, RD, WR). It decodes a 4-byte window, pushes CPU writes into a TX FIFO that drains to a local consumer, and lets the CPU pop bytes from an RX FIFO that a local producer fills. A status register and a control register give software flow control.

## Interface
- BASE_ADDR, 20'h0_8000, window base; bits [1:0] must be 0.
- DEPTH, 8, entries per FIFO; power of two, ≥2.
- CLK  input  1  bus clock; all state on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- ALE  input  1  address latch enable; Address valid while high.
- RD  input  1  active-low read strobe.
- WR  input  1  active-low write strobe.
- Address  input  20  demultiplexed bus address.
- Data  inout  8  bus data; driven only during a selected read, else high-Z.
- tx_valid  output  1  TX FIFO non-empty.
- tx_data  output  8  TX FIFO head.
- tx_ready  input  1  local consumer pops TX head when tx_valid && tx_ready.
- rx_valid  input  1  local producer offers rx_data.
- rx_data  input  8  byte to push into RX FIFO.
- rx_ready  output  1  RX FIFO not full; push when rx_valid && rx_ready.
- irq  output  1  only with BUSFIFO_IRQ_EN (see Configuration).

## Operation
- Register map (offset = latched Address[1:0]): 0 DATA (write pushes TX, read pops RX); 1 STATUS (read-only); 2 CTRL (bit0 flush, bit1 irq enable); 3 reserved, reads 8'h00, writes ignored.
- STATUS: bit0 RX non-empty, bit1 TX full, bit2 TX empty, bit3 RX full, bit4 overflow (sticky), bit5 underflow (sticky), bit6 irq enable, bit7 irq pending (0 without macro). Reading STATUS clears bits 4–5 at read completion.
- FSM: IDLE, SEL, READ, WRITE.
  - IDLE: ALE=1 and Address[19:2]==BASE_ADDR[19:2] → latch offset, SEL.
  - SEL: RD=0 → READ (load read-data register); WR=0 → WRITE; ALE=1 with no match → IDLE; ALE=1 with match → re-latch, stay SEL.
  - READ: RD=1 → IDLE; if offset 0 and RX non-empty, pop RX; if RX empty, return 8'h00, set underflow, no pop.
  - WRITE: capture Data every cycle WR=0; WR=1 → commit last captured byte, IDLE. Offset 0: push TX, or if TX full drop byte and set overflow. Offset 2: update irq enable; bit0=1 empties both FIFOs and clears overflow/underflow.
  - ALE=1 in READ or WRITE: abandon access, no pop/push/commit, re-decode as from IDLE.
- FIFOs: simultaneous push and pop legal; at full both take effect, count unchanged; at empty only push takes effect. Pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1.
- Flush coinciding with local push/pop: flush wins.

## Timing
- Reset: FSM IDLE, FIFOs empty, flags 0, irq enable 0, Data high-Z, tx_valid 0, tx_data 8'h00, rx_ready 1, irq 0.
- Address match sampled on the CLK edge where ALE=1.
- Read data register loaded on the edge RD is first sampled 0; Data driven from the following cycle until RD sampled 1 (one-cycle latency).
- Pop/push/commit occur on the edge RD/WR is sampled 1; STATUS reflects it next cycle.
- Local side: tx_valid/rx_ready are registered-state derived (no combinational path from tx_ready/rx_valid); push/pop visible one cycle later.

## Configuration
- BUSFIFO_IRQ_EN defined: irq port exists; irq = irq enable && RX non-empty, registered (one-cycle lag); STATUS bit7 mirrors it.
- Undefined: no irq port, CTRL bit1 stored and read back but has no effect, STATUS bit7 reads 0.

## Structure
- Package busfifo_pkg: register offsets, STATUS/CTRL bit positions, FSM state enum.
- Sub-module byte_fifo (parameter DEPTH; push/pop, full/empty, count, flush), instantiated twice (TX, RX).

## Test plan
- Reset mid-WRITE: RESET low for one cycle → Data high-Z, tx_valid 0, STATUS reads 8'h04.
- Write 8'hA5 to BASE_ADDR → tx_valid=1, tx_data=8'hA5; tx_ready pulse → tx_valid=0.
- Local push 8'h3C; CPU read BASE_ADDR → Data=8'h3C, then STATUS bit0=0; second read → 8'h00, STATUS bit5=1, cleared after that read.
- DEPTH+1 writes with tx_ready=0 → STATUS=8'h12 (full, overflow), 9th byte absent from drained sequence.
- Write CTRL 8'h03 with both FIFOs non-empty → both empty; with BUSFIFO_IRQ_EN, later RX push raises irq one cycle after rx_valid.
- Access to BASE_ADDR+4 or ALE mid-read → no Data drive, no FIFO change.
